// File: rtl/dso_acq.sv
`default_nettype none
// ============================================================================
//  Module   : dso_acq
//  Purpose  : DSO acquisition engine. Decimates NCH channels of DW-bit samples
//             (plain or peak-detect min/max), writes them to a circular SRAM
//             buffer with programmable pre/post-trigger lengths, and reports
//             the trigger address and completion to the register block.
//  Ports    : clk, rst          - clock, synchronous active-high reset
//             i_run             - level, 1 = acquire, 0 = stop/abort
//             i_mode            - 0 = normal sample, 1 = peak detect
//             i_deci            - one output per i_deci+1 clocks
//             i_pretrig         - writes before the trigger is armed
//             i_posttrig        - writes from the trigger onward
//             i_din             - live samples, channel k at [k*DW +: DW]
//             i_trig            - trigger pulse
//             o_wr_en/addr/data - one-cycle SRAM write (always accepted)
//             o_trig_addr       - address of the first post-trigger sample
//             o_armed, o_done   - state flags
//             o_state           - FSM state code
//  Revision : 1.0 - initial release
// ============================================================================
module dso_acq #(
  parameter int DW   = 8,
  parameter int NCH  = 2,
  parameter int AW   = 18,
  parameter int DECW = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_run,
  input  logic              i_mode,
  input  logic [DECW-1:0]   i_deci,
  input  logic [AW-1:0]     i_pretrig,
  input  logic [AW-1:0]     i_posttrig,
  input  logic [NCH*DW-1:0] i_din,
  input  logic              i_trig,
  output logic              o_wr_en,
  output logic [AW-1:0]     o_wr_addr,
  output logic [NCH*DW-1:0] o_wr_data,
  output logic [AW-1:0]     o_trig_addr,
  output logic              o_armed,
  output logic              o_done,
  output logic [2:0]        o_state
);

  localparam logic [DECW-1:0] c_ONE_D = {{(DECW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0]   c_ONE_A = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0]   c_ZERO_A = '0;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE   = 3'd1,
    S_ARMED = 3'd2,
    S_POST  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_next;

  // Configuration captured when leaving IDLE
  logic              r_mode;
  logic [DECW-1:0]   r_deci;
  logic [AW-1:0]     r_pretrig;
  logic [AW-1:0]     r_posttrig;

  logic [DECW-1:0]   r_dcnt;
  logic [AW-1:0]     r_wcnt;
  logic [AW-1:0]     w_wcnt_next;
  logic [AW-1:0]     r_ptr;
  logic              r_par;      // window parity: 0 = write min, 1 = write max
  logic              r_first;    // next clock starts a new peak window
  logic [NCH*DW-1:0] r_min;
  logic [NCH*DW-1:0] r_max;
  logic [NCH*DW-1:0] w_min;
  logic [NCH*DW-1:0] w_max;
  logic [NCH*DW-1:0] w_wdata;

  logic              r_wr_en;
  logic [AW-1:0]     r_wr_addr;
  logic [NCH*DW-1:0] r_wr_data;
  logic [AW-1:0]     r_trig_addr;

  logic              w_active;
  logic              w_dwrap;
  logic              w_strobe;
  logic              w_issue;
  logic              w_trig_latch;

  assign w_active = (r_state == S_PRE) || (r_state == S_ARMED) || (r_state == S_POST);
  assign w_dwrap  = (r_dcnt == r_deci);
  // A strobe coinciding with run=0 is dropped along with its write
  assign w_strobe = w_active && w_dwrap && i_run;

  // Running min/max per channel, including the current sample
  generate
    for (genvar k = 0; k < NCH; k++) begin : g_ch
      logic [DW-1:0] w_d;
      assign w_d = i_din[k*DW +: DW];
      assign w_min[k*DW +: DW] = (r_first || (w_d < r_min[k*DW +: DW])) ? w_d : r_min[k*DW +: DW];
      assign w_max[k*DW +: DW] = (r_first || (w_d > r_max[k*DW +: DW])) ? w_d : r_max[k*DW +: DW];
    end
  endgenerate

  assign w_wdata = !r_mode ? i_din : (r_par ? w_max : w_min);

  // Next-state and write-issue decode
  always_comb begin
    w_next       = r_state;
    w_issue      = 1'b0;
    w_trig_latch = 1'b0;
    w_wcnt_next  = r_wcnt;
    case (r_state)
      S_IDLE: begin
        w_wcnt_next = '0;
        if (i_run) w_next = (i_pretrig == c_ZERO_A) ? S_ARMED : S_PRE;
      end
      S_PRE: begin
        if (w_strobe) begin
          w_issue = 1'b1;
          if (r_wcnt == r_pretrig - c_ONE_A) begin
            w_next      = S_ARMED;
            w_wcnt_next = '0;
          end else begin
            w_wcnt_next = r_wcnt + c_ONE_A;
          end
        end
      end
      S_ARMED: begin
        if (i_trig) begin
          // The next write (this clock or later) lands at the current pointer
          w_trig_latch = 1'b1;
          if (r_posttrig == c_ZERO_A) begin
            w_next = S_DONE;
          end else begin
            w_issue = w_strobe;
            if (w_strobe && (r_posttrig == c_ONE_A)) begin
              w_next = S_DONE;
            end else begin
              w_next      = S_POST;
              w_wcnt_next = w_strobe ? c_ONE_A : c_ZERO_A;
            end
          end
        end else begin
          w_issue = w_strobe;
        end
      end
      S_POST: begin
        if (w_strobe) begin
          w_issue = 1'b1;
          if (r_wcnt == r_posttrig - c_ONE_A) w_next = S_DONE;
          else                                w_wcnt_next = r_wcnt + c_ONE_A;
        end
      end
      S_DONE:  ;
      default: w_next = S_IDLE;
    endcase
    if (!i_run) begin
      w_next       = S_IDLE;
      w_issue      = 1'b0;
      w_trig_latch = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode      <= 1'b0;
      r_deci      <= '0;
      r_pretrig   <= '0;
      r_posttrig  <= '0;
      r_dcnt      <= '0;
      r_wcnt      <= '0;
      r_ptr       <= '0;
      r_par       <= 1'b0;
      r_first     <= 1'b1;
      r_min       <= '0;
      r_max       <= '0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_trig_addr <= '0;
    end else begin
      r_wcnt  <= w_wcnt_next;
      r_wr_en <= w_issue;
      if (r_state == S_IDLE) begin
        r_dcnt  <= '0;
        r_ptr   <= '0;
        r_par   <= 1'b0;
        r_first <= 1'b1;
        if (i_run) begin
          r_mode     <= i_mode;
          r_deci     <= i_deci;
          r_pretrig  <= i_pretrig;
          r_posttrig <= i_posttrig;
        end
      end else if (w_active) begin
        r_dcnt  <= w_dwrap ? '0 : r_dcnt + c_ONE_D;
        r_min   <= w_min;
        r_max   <= w_max;
        r_first <= w_dwrap;
        if (w_dwrap) r_par <= ~r_par;
      end
      if (w_issue) begin
        r_wr_addr <= r_ptr;
        r_wr_data <= w_wdata;
        r_ptr     <= r_ptr + c_ONE_A;
      end
      if (w_trig_latch) r_trig_addr <= r_ptr;
    end
  end

  assign o_wr_en     = r_wr_en;
  assign o_wr_addr   = r_wr_addr;
  assign o_wr_data   = r_wr_data;
  assign o_trig_addr = r_trig_addr;
  assign o_armed     = (r_state == S_ARMED);
  assign o_done      = (r_state == S_DONE);
  assign o_state     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_dso_acq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dso_acq
//  Purpose  : Directed self-checking bench for dso_acq (default AW=18 instance
//             plus an AW=4 instance for address wrap).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dso_acq;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        mode;
  logic [15:0] deci;
  logic [17:0] pretrig;
  logic [17:0] posttrig;
  logic [15:0] din;
  logic        trig;

  logic        wr_en,  wr_en4;
  logic [17:0] wr_addr;
  logic [3:0]  wr_addr4;
  logic [15:0] wr_data, wr_data4;
  logic [17:0] trig_addr;
  logic [3:0]  trig_addr4;
  logic        armed, armed4, done, done4;
  logic [2:0]  state, state4;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dso_acq #(.DW(8), .NCH(2), .AW(18), .DECW(16)) dut (
    .clk(clk), .rst(rst), .i_run(run), .i_mode(mode), .i_deci(deci),
    .i_pretrig(pretrig), .i_posttrig(posttrig), .i_din(din), .i_trig(trig),
    .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
    .o_trig_addr(trig_addr), .o_armed(armed), .o_done(done), .o_state(state)
  );

  dso_acq #(.DW(8), .NCH(2), .AW(4), .DECW(16)) dut4 (
    .clk(clk), .rst(rst), .i_run(run), .i_mode(mode), .i_deci(deci),
    .i_pretrig(pretrig[3:0]), .i_posttrig(posttrig[3:0]), .i_din(din), .i_trig(trig),
    .o_wr_en(wr_en4), .o_wr_addr(wr_addr4), .o_wr_data(wr_data4),
    .o_trig_addr(trig_addr4), .o_armed(armed4), .o_done(done4), .o_state(state4)
  );

  // Advance past the next active edge; outputs then reflect that edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    run  = 1'b0;
    trig = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; run = 1'b0; mode = 1'b0; deci = '0; pretrig = '0; posttrig = '0;
    din = '0; trig = 1'b0;
    tick(); tick();
    if (state !== 3'd0 || wr_en !== 1'b0 || done !== 1'b0 || armed !== 1'b0 || trig_addr !== 18'd0) begin
      $display("FAIL reset: state=%0d wr_en=%b done=%b armed=%b trig_addr=%0d, want 0", state, wr_en, done, armed, trig_addr);
      n_fail++;
    end
    n_tests++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_normal();
    logic [7:0] kb;
    logic       ew;
    logic [2:0] es;
    run = 1'b1; mode = 1'b0; deci = 16'd0; pretrig = 18'd4; posttrig = 18'd3;
    tick();  // E0: IDLE -> PRE
    if (state !== 3'd1) begin
      $display("FAIL normal_start: state=%0d want 1", state); n_fail++;
    end
    n_tests++;
    for (int k = 1; k <= 14; k++) begin
      kb   = 8'(k);
      din  = {kb ^ 8'hA5, kb};
      trig = (k == 10);
      tick();
      trig = 1'b0;
      ew = (k <= 12);
      es = (k < 4) ? 3'd1 : (k < 10) ? 3'd2 : (k < 12) ? 3'd3 : 3'd4;
      if (wr_en !== ew || state !== es) begin
        $display("FAIL normal_cyc%0d: wr_en=%b state=%0d want wr_en=%b state=%0d", k, wr_en, state, ew, es);
        n_fail++;
      end
      n_tests++;
      if (ew) begin
        if (wr_addr !== 18'(k - 1) || wr_data !== {kb ^ 8'hA5, kb}) begin
          $display("FAIL normal_wr%0d: addr=%0d data=%h want addr=%0d data=%h", k, wr_addr, wr_data, k - 1, {kb ^ 8'hA5, kb});
          n_fail++;
        end
        n_tests++;
      end
    end
    if (trig_addr !== 18'd9 || done !== 1'b1) begin
      $display("FAIL normal_done: trig_addr=%0d done=%b want 9/1", trig_addr, done); n_fail++;
    end
    n_tests++;
    run = 1'b0;
    tick();
    if (state !== 3'd0 || done !== 1'b0 || trig_addr !== 18'd9) begin
      $display("FAIL normal_stop: state=%0d done=%b trig_addr=%0d want 0/0/9", state, done, trig_addr); n_fail++;
    end
    n_tests++;
    go_idle();
  endtask

  task automatic test_decimation();
    logic ew;
    run = 1'b1; mode = 1'b0; deci = 16'd3; pretrig = 18'd100; posttrig = 18'd1;
    tick();
    for (int k = 1; k <= 12; k++) begin
      din = 16'(k - 1);
      tick();
      ew = ((k % 4) == 0);
      if (wr_en !== ew) begin
        $display("FAIL deci_en%0d: wr_en=%b want %b", k, wr_en, ew); n_fail++;
      end
      n_tests++;
      if (ew) begin
        if (wr_data !== 16'(k - 1) || wr_addr !== 18'(k / 4 - 1)) begin
          $display("FAIL deci_wr%0d: data=%0d addr=%0d want data=%0d addr=%0d", k, wr_data, wr_addr, k - 1, k / 4 - 1);
          n_fail++;
        end
        n_tests++;
      end
    end
    go_idle();
  endtask

  task automatic test_peak();
    logic [7:0]  pat [4];
    logic        ew;
    logic [15:0] ed;
    pat[0] = 8'd5; pat[1] = 8'd9; pat[2] = 8'd1; pat[3] = 8'd7;
    run = 1'b1; mode = 1'b1; deci = 16'd7; pretrig = 18'd100; posttrig = 18'd1;
    tick();
    for (int k = 1; k <= 24; k++) begin
      din = {8'h80, pat[(k - 1) % 4]};
      tick();
      ew = ((k % 8) == 0);
      ed = (k == 16) ? 16'h8009 : 16'h8001;
      if (wr_en !== ew) begin
        $display("FAIL peak_en%0d: wr_en=%b want %b", k, wr_en, ew); n_fail++;
      end
      n_tests++;
      if (ew) begin
        if (wr_data !== ed) begin
          $display("FAIL peak_wr%0d: data=%h want %h", k, wr_data, ed); n_fail++;
        end
        n_tests++;
      end
    end
    mode = 1'b0;
    go_idle();
  endtask

  task automatic test_wrap();
    logic [3:0] last;
    logic       ew;
    last = '0;
    run = 1'b1; mode = 1'b0; deci = 16'd0; pretrig = 18'd10; posttrig = 18'd12;
    tick();
    for (int k = 1; k <= 33; k++) begin
      din  = 16'(k);
      trig = (k == 20);
      tick();
      trig = 1'b0;
      ew = (k <= 31);
      if (wr_en4 !== ew) begin
        $display("FAIL wrap_en%0d: wr_en=%b want %b", k, wr_en4, ew); n_fail++;
      end
      n_tests++;
      if (ew) begin
        if (wr_addr4 !== 4'((k - 1) % 16)) begin
          $display("FAIL wrap_addr%0d: addr=%0d want %0d", k, wr_addr4, (k - 1) % 16); n_fail++;
        end
        n_tests++;
        last = wr_addr4;
      end
    end
    if (trig_addr4 !== 4'd3 || done4 !== 1'b1 || last !== 4'(trig_addr4 + 4'd11)) begin
      $display("FAIL wrap_trig: trig_addr=%0d done=%b last=%0d want 3/1/14", trig_addr4, done4, last); n_fail++;
    end
    n_tests++;
    go_idle();
  endtask

  task automatic test_edges();
    // trig on the PRE->ARMED clock is ignored
    run = 1'b1; deci = 16'd0; pretrig = 18'd2; posttrig = 18'd2;
    tick();
    tick();               // E1
    trig = 1'b1; tick();  // E2: last pre write, -> ARMED
    trig = 1'b0;
    if (state !== 3'd2 || armed !== 1'b1) begin
      $display("FAIL edge_pretrig_ignore: state=%0d armed=%b want 2/1", state, armed); n_fail++;
    end
    n_tests++;
    tick();               // E3 ARMED write addr 2
    trig = 1'b1; tick();  // E4 trigger, addr 3
    trig = 1'b0;
    tick();               // E5 -> DONE
    if (trig_addr !== 18'd3 || state !== 3'd4 || wr_addr !== 18'd4) begin
      $display("FAIL edge_trig: trig_addr=%0d state=%0d last_addr=%0d want 3/4/4", trig_addr, state, wr_addr); n_fail++;
    end
    n_tests++;
    go_idle();

    // posttrig=0: DONE on trigger with no write
    run = 1'b1; pretrig = 18'd1; posttrig = 18'd0;
    tick();
    tick();               // E1 write addr 0, -> ARMED
    trig = 1'b1; tick();  // E2
    trig = 1'b0;
    if (wr_en !== 1'b0 || state !== 3'd4 || trig_addr !== 18'd1) begin
      $display("FAIL edge_post0: wr_en=%b state=%0d trig_addr=%0d want 0/4/1", wr_en, state, trig_addr); n_fail++;
    end
    n_tests++;
    tick();
    if (wr_en !== 1'b0 || done !== 1'b1) begin
      $display("FAIL edge_post0_hold: wr_en=%b done=%b want 0/1", wr_en, done); n_fail++;
    end
    n_tests++;
    go_idle();

    // run drop while ARMED
    run = 1'b1; pretrig = 18'd1; posttrig = 18'd5;
    tick(); tick(); tick();  // E0..E2
    run = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (wr_en !== 1'b0 || state !== 3'd0) begin
        $display("FAIL edge_abort%0d: wr_en=%b state=%0d want 0/0", k, wr_en, state); n_fail++;
      end
      n_tests++;
    end
    go_idle();
  endtask

  task automatic test_reset_mid_post();
    run = 1'b1; deci = 16'd0; pretrig = 18'd1; posttrig = 18'd10;
    tick(); tick();        // E0, E1 -> ARMED
    trig = 1'b1; tick();   // E2 -> POST
    trig = 1'b0;
    tick();                // E3
    if (state !== 3'd3 || trig_addr !== 18'd1) begin
      $display("FAIL rstpost_pre: state=%0d trig_addr=%0d want 3/1", state, trig_addr); n_fail++;
    end
    n_tests++;
    rst = 1'b1;
    tick();
    if (state !== 3'd0 || wr_en !== 1'b0 || done !== 1'b0 || trig_addr !== 18'd0) begin
      $display("FAIL rstpost: state=%0d wr_en=%b done=%b trig_addr=%0d want 0", state, wr_en, done, trig_addr); n_fail++;
    end
    n_tests++;
    rst = 1'b0;
    go_idle();
  endtask

  initial begin
    test_reset();
    test_normal();
    test_decimation();
    test_peak();
    test_wrap();
    test_edges();
    test_reset_mid_post();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
